tx_ctrl_fsm: RTL

TX_CTRL_FSM -- requirements
Module: tx_ctrl_fsm

---
 rtl/tx_ctrl_fsm_pkg.sv | 68 ++++++
 rtl/tx_ctrl_fsm_hold_timer.sv | 30 +++
 rtl/tx_ctrl_fsm.sv | 139 +++++++++++++
 3 files changed

// File: rtl/tx_ctrl_fsm_pkg.sv
// Shared C-PHY TX definitions: lane FSM states, line-state codes, output bundle.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package tx_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    ST_STOP       = 4'd0,
    ST_HS_RQST    = 4'd1,
    ST_HS_PREPARE = 4'd2,
    ST_HS_GO      = 4'd3,
    ST_HS_TRAIL   = 4'd4,
    ST_LP_RQST    = 4'd5,
    ST_LP_YIELD   = 4'd6,
    ST_ESC_RQST   = 4'd7,
    ST_ESC_GO     = 4'd8,
    ST_ULPS       = 4'd9,
    ST_ULPS_EXIT  = 4'd10,
    ST_TA_RQST    = 4'd11,
    ST_TA_GO      = 4'd12,
    ST_TA_DONE    = 4'd13
  } tx_state_t;

  // Line-state codes understood by the downstream line-level decoder.
  localparam logic [1:0] LINE_LP111 = 2'b00;
  localparam logic [1:0] LINE_LP001 = 2'b01;
  localparam logic [1:0] LINE_LP000 = 2'b10;
  localparam logic [1:0] LINE_LP100 = 2'b11;

  typedef struct packed {
    logic [1:0] ctrl;
    logic       hs_en;
    logic       ready_hs;
    logic       stopstate;
    logic       ulps_active_not;
    logic       lp_drv_en;
    logic       direction;
  } tx_out_t;

  // Pure state-to-output decode; unknown encodings look like STOP.
  function automatic tx_out_t decode_outputs(tx_state_t st);
    tx_out_t o;
    o = '{ctrl: LINE_LP000, hs_en: 1'b0, ready_hs: 1'b0, stopstate: 1'b0,
          ulps_active_not: 1'b1, lp_drv_en: 1'b1, direction: 1'b0};
    case (st)
      ST_HS_RQST, ST_ESC_RQST:            o.ctrl = LINE_LP001;
      ST_HS_PREPARE, ST_LP_YIELD,
      ST_ESC_GO, ST_TA_GO:                o.ctrl = LINE_LP000;
      ST_HS_GO: begin
        o.hs_en    = 1'b1;
        o.ready_hs = 1'b1;
      end
      ST_HS_TRAIL:                        o.hs_en = 1'b1;
      ST_LP_RQST, ST_ULPS_EXIT, ST_TA_RQST: o.ctrl = LINE_LP100;
      ST_ULPS:                            o.ulps_active_not = 1'b0;
      ST_TA_DONE: begin
        o.ctrl      = LINE_LP111;
        o.lp_drv_en = 1'b0;
        o.direction = 1'b1;
      end
      default: begin
        o.ctrl      = LINE_LP111;
        o.stopstate = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/tx_ctrl_fsm_hold_timer.sv
// 8-bit hold down-counter: load, count down to zero and stick, flag zero.
// Latency: load/clear take effect on the next rising edge.
// Backpressure: none; clear beats load beats decrement.
module tx_hold_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [7:0] i_value,
  output logic       o_zero
);

  logic [7:0] r_cnt;

  // Count down to zero and hold there until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/tx_ctrl_fsm.sv
// C-PHY TX lane control FSM: sequences HS, escape/ULPS and turnaround line states.
// Latency: outputs registered, changing on the same edge as the state.
// Backpressure: none; level requests are sampled each edge, entry sequences run to completion.
module tx_ctrl_fsm
  import tx_ctrl_fsm_pkg::*;
#(
  parameter int T_LPX        = 4,
  parameter int T_HS_PREPARE = 3,
  parameter int T_HS_TRAIL   = 5,
  parameter int T_WAKEUP     = 10,
  parameter int T_TA_GO      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       TxRequestHS,
  input  logic       TxRequestEsc,
  input  logic       TxUlpsEsc,
  input  logic       TxUlpsExit,
  input  logic       TurnRequest,
  input  logic       ForceTxStopmode,
  output logic [1:0] TxCtrlOut,
  output logic       HsEn,
  output logic       TxReadyHS,
  output logic       Stopstate,
  output logic       UlpsActiveNot,
  output logic       LpDrvEn,
  output logic       Direction
);

  // Counter loads hold-1 so a timed state spans exactly its hold in cycles.
  localparam logic [7:0] L_LPX     = 8'(T_LPX - 1);
  localparam logic [7:0] L_PREPARE = 8'(T_HS_PREPARE - 1);
  localparam logic [7:0] L_TRAIL   = 8'(T_HS_TRAIL - 1);
  localparam logic [7:0] L_WAKEUP  = 8'(T_WAKEUP - 1);
  localparam logic [7:0] L_TA_GO   = 8'(T_TA_GO - 1);

  tx_state_t  r_state;
  tx_state_t  w_nxt;
  tx_out_t    r_out;
  logic       r_exit_blk;
  logic       w_load;
  logic [7:0] w_load_val;
  logic       w_cnt_zero;

  tx_hold_timer u_hold_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (ForceTxStopmode),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_cnt_zero)
  );

  // Next-state rules; forced stop overrides everything.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_STOP: begin
        if (TxRequestHS)       w_nxt = ST_HS_RQST;
        else if (TurnRequest)  w_nxt = ST_TA_RQST;
        else if (TxRequestEsc) w_nxt = ST_LP_RQST;
      end
      ST_HS_RQST:    if (w_cnt_zero) w_nxt = ST_HS_PREPARE;
      ST_HS_PREPARE: if (w_cnt_zero) w_nxt = ST_HS_GO;
      ST_HS_GO:      if (!TxRequestHS) w_nxt = ST_HS_TRAIL;
      ST_HS_TRAIL:   if (w_cnt_zero) w_nxt = ST_STOP;
      ST_LP_RQST:    if (w_cnt_zero) w_nxt = ST_LP_YIELD;
      ST_LP_YIELD:   if (w_cnt_zero) w_nxt = ST_ESC_RQST;
      ST_ESC_RQST:   if (w_cnt_zero) w_nxt = ST_ESC_GO;
      ST_ESC_GO:     if (w_cnt_zero) w_nxt = TxUlpsEsc ? ST_ULPS : ST_STOP;
      // An exit request still held over from the previous wake-up is ignored.
      ST_ULPS:       if (TxUlpsExit && !r_exit_blk) w_nxt = ST_ULPS_EXIT;
      ST_ULPS_EXIT:  if (w_cnt_zero) w_nxt = ST_STOP;
      ST_TA_RQST:    if (w_cnt_zero) w_nxt = ST_TA_GO;
      ST_TA_GO:      if (w_cnt_zero) w_nxt = ST_TA_DONE;
      ST_TA_DONE:    if (!TurnRequest) w_nxt = ST_STOP;
      default:       w_nxt = ST_STOP;
    endcase
    if (ForceTxStopmode) w_nxt = ST_STOP;
  end

  // Load the hold counter on entry to a timed state.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = 8'd0;
    if (w_nxt != r_state) begin
      case (w_nxt)
        ST_HS_RQST, ST_LP_RQST, ST_LP_YIELD,
        ST_ESC_RQST, ST_ESC_GO, ST_TA_RQST: begin
          w_load     = 1'b1;
          w_load_val = L_LPX;
        end
        ST_HS_PREPARE: begin
          w_load     = 1'b1;
          w_load_val = L_PREPARE;
        end
        ST_HS_TRAIL: begin
          w_load     = 1'b1;
          w_load_val = L_TRAIL;
        end
        ST_ULPS_EXIT: begin
          w_load     = 1'b1;
          w_load_val = L_WAKEUP;
        end
        ST_TA_GO: begin
          w_load     = 1'b1;
          w_load_val = L_TA_GO;
        end
        default: begin
          w_load     = 1'b0;
          w_load_val = 8'd0;
        end
      endcase
    end
  end

  // State register with outputs decoded from the next state, so both move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_STOP;
      r_out      <= decode_outputs(ST_STOP);
      r_exit_blk <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_out   <= decode_outputs(w_nxt);
      if (r_state == ST_ULPS && w_nxt == ST_ULPS_EXIT) r_exit_blk <= 1'b1;
      else if (!TxUlpsExit)                            r_exit_blk <= 1'b0;
    end
  end

  assign TxCtrlOut     = r_out.ctrl;
  assign HsEn          = r_out.hs_en;
  assign TxReadyHS     = r_out.ready_hs;
  assign Stopstate     = r_out.stopstate;
  assign UlpsActiveNot = r_out.ulps_active_not;
  assign LpDrvEn       = r_out.lp_drv_en;
  assign Direction     = r_out.direction;

endmodule
